// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared pulse type, default limits and clamp helper for the servo PWM driver
package servo_pkg;

    typedef logic [23:0] pulse_t;

    localparam pulse_t DEF_PERIOD_CYCLES = 24'd1000000;
    localparam pulse_t DEF_MIN_PULSE     = 24'd50000;
    localparam pulse_t DEF_MAX_PULSE     = 24'd250000;
    localparam pulse_t DEF_RESET_PULSE   = 24'd120000;
    localparam pulse_t DEF_SLEW_STEP     = 24'd2000;

    function automatic pulse_t clamp_pulse(input pulse_t value, input pulse_t lo, input pulse_t hi);
        if (value < lo)
            return lo;
        else if (value > hi)
            return hi;
        else
            return value;
    endfunction

endpackage

// File: rtl/servo_pwm_driver_if.sv
// rtl/servo_pwm_driver_if.sv - command inputs and PWM/status outputs of the servo PWM driver
interface servo_pwm_driver_if;
    import servo_pkg::*;

    pulse_t shoulder_angle;
    pulse_t elbow_angle;
    logic   enable;
    logic   shoulder_pwm;
    logic   elbow_pwm;
    logic   frame_start;
    logic   busy;

    modport master (
        output shoulder_angle, elbow_angle, enable,
        input  shoulder_pwm, elbow_pwm, frame_start, busy
    );

    modport slave (
        input  shoulder_angle, elbow_angle, enable,
        output shoulder_pwm, elbow_pwm, frame_start, busy
    );

endinterface

// File: rtl/servo_channel.sv
// rtl/servo_channel.sv - one joint: clamp, per-frame move of cur toward target (slewed when SLEW_LIMIT_EN), registered PWM and busy
module servo_channel
    import servo_pkg::*;
#(
    parameter pulse_t MIN_PULSE   = DEF_MIN_PULSE,
    parameter pulse_t MAX_PULSE   = DEF_MAX_PULSE,
    parameter pulse_t RESET_PULSE = DEF_RESET_PULSE,
    parameter pulse_t SLEW_STEP   = DEF_SLEW_STEP
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_frame_end,
    input  logic   i_enable,
    input  pulse_t i_angle,
    input  pulse_t i_cnt_next,
    output logic   o_pwm,
    output logic   o_busy
);

`ifdef SLEW_LIMIT_EN
    localparam pulse_t STEP = SLEW_STEP;
`else
    // A full-range step makes every move a snap to target, i.e. a single-frame jump.
    localparam pulse_t STEP = SLEW_STEP | 24'hFF_FFFF;
`endif
    localparam logic signed [24:0] STEP_S = $signed({1'b0, STEP});

    pulse_t             r_cur;
    pulse_t             w_tgt;
    pulse_t             w_cur_next;
    logic signed [24:0] w_diff;
    logic               r_pwm;
    logic               r_busy;

    assign w_tgt  = clamp_pulse(i_angle, MIN_PULSE, MAX_PULSE);
    assign w_diff = $signed({1'b0, w_tgt}) - $signed({1'b0, r_cur});

    always_comb begin
        w_cur_next = r_cur;
        if (i_frame_end) begin
            if (w_diff > STEP_S)
                w_cur_next = r_cur + STEP;
            else if (w_diff < -STEP_S)
                w_cur_next = r_cur - STEP;
            else
                w_cur_next = w_tgt;
        end
    end

    // Compare against the value cur takes on this edge so a new width starts exactly at counter 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur  <= RESET_PULSE;
            r_pwm  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_cur  <= w_cur_next;
            r_pwm  <= i_enable && (i_cnt_next < w_cur_next);
            r_busy <= (r_cur != w_tgt);
        end
    end

    assign o_pwm  = r_pwm;
    assign o_busy = r_busy;

endmodule

// File: rtl/servo_pwm_driver.sv
// rtl/servo_pwm_driver.sv - frame counter, frame_start and two servo_channel instances driving shoulder/elbow PWM
module servo_pwm_driver
    import servo_pkg::*;
#(
    parameter pulse_t PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter pulse_t MIN_PULSE     = DEF_MIN_PULSE,
    parameter pulse_t MAX_PULSE     = DEF_MAX_PULSE,
    parameter pulse_t RESET_PULSE   = DEF_RESET_PULSE,
    parameter pulse_t SLEW_STEP     = DEF_SLEW_STEP
) (
    input  logic              clk,
    input  logic              reset,
    servo_pwm_driver_if.slave bus
);

    pulse_t r_cnt;
    pulse_t w_cnt_next;
    logic   w_frame_end;
    logic   r_frame_start;
    logic   w_sh_pwm;
    logic   w_el_pwm;
    logic   w_sh_busy;
    logic   w_el_busy;

    assign w_frame_end = (r_cnt == PERIOD_CYCLES - 24'd1);
    assign w_cnt_next  = w_frame_end ? '0 : r_cnt + 24'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_next;
            r_frame_start <= w_frame_end;
        end
    end

    servo_channel #(
        .MIN_PULSE  (MIN_PULSE),
        .MAX_PULSE  (MAX_PULSE),
        .RESET_PULSE(RESET_PULSE),
        .SLEW_STEP  (SLEW_STEP)
    ) u_shoulder (
        .clk        (clk),
        .reset      (reset),
        .i_frame_end(w_frame_end),
        .i_enable   (bus.enable),
        .i_angle    (bus.shoulder_angle),
        .i_cnt_next (w_cnt_next),
        .o_pwm      (w_sh_pwm),
        .o_busy     (w_sh_busy)
    );

    servo_channel #(
        .MIN_PULSE  (MIN_PULSE),
        .MAX_PULSE  (MAX_PULSE),
        .RESET_PULSE(RESET_PULSE),
        .SLEW_STEP  (SLEW_STEP)
    ) u_elbow (
        .clk        (clk),
        .reset      (reset),
        .i_frame_end(w_frame_end),
        .i_enable   (bus.enable),
        .i_angle    (bus.elbow_angle),
        .i_cnt_next (w_cnt_next),
        .o_pwm      (w_el_pwm),
        .o_busy     (w_el_busy)
    );

    assign bus.shoulder_pwm = w_sh_pwm;
    assign bus.elbow_pwm    = w_el_pwm;
    assign bus.frame_start  = r_frame_start;
    assign bus.busy         = w_sh_busy | w_el_busy;

endmodule
